// File: rtl/rs232_pkg.sv
// Shared RS232 constants and baud arithmetic for the transmit and receive paths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rs232_pkg;

    localparam int FRAME_BITS_8N1 = 10;
    localparam int FRAME_BITS_8E1 = 11;

    // Bit counter value meaning "no frame in flight"; frame slots count down to it.
    localparam logic [3:0] BIT_CNT_IDLE = 4'd0;

    // Clocks per bit, truncated toward zero.
    function automatic longint baud_count_full(input real clock_freq, input real baud_rate);
        real    ratio;
        longint n;
        ratio = clock_freq / baud_rate;
        n     = longint'(ratio);
        if (real'(n) > ratio) begin
            n = n - 64'sd1;
        end
        return n;
    endfunction

    // Half a bit period, used by the receiver to land on mid-bit.
    function automatic longint baud_count_half(input real clock_freq, input real baud_rate);
        return baud_count_full(clock_freq, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/rs232_baud_gen.sv
// Bit-period tick generator: down-counter whose sign bit flags underflow.
// Latency: first tick COUNT_FULL clocks after hold drops; then every COUNT_FULL clocks.
// Backpressure: none; hold parks the counter at its reload value.
module rs232_baud_gen #(
    parameter longint COUNT_FULL = 10
) (
    input  logic clock,
    input  logic resetn,
    input  logic hold,
    output logic tick
);
    localparam int             W      = $clog2(COUNT_FULL - 1) + 1;
    localparam logic [W-1:0]   RELOAD = W'(COUNT_FULL - 64'sd2);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = cnt_q[W-1];

    // Count down; reload on underflow or while held so a period always starts full.
    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (hold || cnt_q[W-1]) begin
            cnt_d = RELOAD;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/axis_to_rs232.sv
// AXI-stream byte to 8N1 (8E1 with RS232_TX_PARITY_EN) serial frame, gated by CTSn flow control.
// Latency: txd_pin falls 1 clock after the ivalid&&iready handshake; each bit lasts BAUD_COUNT_FULL clocks.
// Backpressure: iready is low during a frame and while CTSn is deasserted; a started frame always completes.
module axis_to_rs232
    import rs232_pkg::*;
#(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic       txd_pin,
    input  logic       ctsn_pin,
    output logic       busy
);
    localparam longint BAUD_COUNT_FULL = baud_count_full(CLOCK_FREQ, BAUD_RATE);

`ifdef RS232_TX_PARITY_EN
    localparam int FRAME_BITS = FRAME_BITS_8E1;
`else
    localparam int FRAME_BITS = FRAME_BITS_8N1;
`endif
    localparam logic [3:0] FRAME_LOAD = 4'(FRAME_BITS);

    if (BAUD_COUNT_FULL < 3) begin : g_baud_check
        $error("axis_to_rs232: CLOCK_FREQ/BAUD_RATE must be at least 3");
    end

    logic [1:0]            ctsn_sync_q, ctsn_sync_d;
    logic [FRAME_BITS-1:0] shift_q, shift_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic                  iready_q, iready_d;
    logic                  busy_q, busy_d;
    logic                  cts, idle, fire, tick;

    assign cts     = !ctsn_sync_q[1];
    assign idle    = (bit_cnt_q == BIT_CNT_IDLE);
    assign fire    = ivalid && iready_q;
    assign iready  = iready_q;
    assign busy    = busy_q;
    assign txd_pin = shift_q[0];

    rs232_baud_gen #(
        .COUNT_FULL (BAUD_COUNT_FULL)
    ) u_baud (
        .clock  (clock),
        .resetn (resetn),
        .hold   (idle),
        .tick   (tick)
    );

    // Load a frame on handshake, shift one bit per tick, and derive next-cycle iready/busy.
    always_comb begin
        ctsn_sync_d = {ctsn_sync_q[0], ctsn_pin};
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        if (fire) begin
`ifdef RS232_TX_PARITY_EN
            shift_d = {1'b1, ^idata, idata, 1'b0};
`else
            shift_d = {1'b1, idata, 1'b0};
`endif
            bit_cnt_d = FRAME_LOAD;
        end else if (!idle && tick) begin
            // Shift in 1s so the line idles high once the stop bit has gone out.
            shift_d   = {1'b1, shift_q[FRAME_BITS-1:1]};
            bit_cnt_d = bit_cnt_q - 4'd1;
        end
        // CTS only matters when no frame is in flight; iready rises on the edge the stop bit ends.
        iready_d = (bit_cnt_d == BIT_CNT_IDLE) && cts;
        busy_d   = (bit_cnt_d != BIT_CNT_IDLE);
    end

    // State registers; reset drops the line to idle-high at once and abandons any frame.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ctsn_sync_q <= 2'b11;
            shift_q     <= '1;
            bit_cnt_q   <= BIT_CNT_IDLE;
            iready_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            ctsn_sync_q <= ctsn_sync_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            iready_q    <= iready_d;
            busy_q      <= busy_d;
        end
    end

endmodule

// File: tb/tb_axis_to_rs232.sv
// Bench for axis_to_rs232 at 10 clocks per bit; a UART receiver model decodes txd_pin.
// Latency: n/a.
// Backpressure: n/a.
module tb_axis_to_rs232;

    localparam int BIT = 10;
`ifdef RS232_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif

    logic       clock;
    logic       resetn;
    logic [7:0] idata;
    logic       ivalid;
    logic       iready;
    logic       txd_pin;
    logic       ctsn_pin;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [8:0] rxq[$];

    axis_to_rs232 #(
        .CLOCK_FREQ (1000000.0),
        .BAUD_RATE  (100000.0)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .idata    (idata),
        .ivalid   (ivalid),
        .iready   (iready),
        .txd_pin  (txd_pin),
        .ctsn_pin (ctsn_pin),
        .busy     (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want test done");
        $fatal(1, "watchdog");
    end

    // Reference receiver: start edge, sample mid-bit, LSB first; bit 8 of each entry flags a framing/parity error.
    always begin : rx_model
        logic [7:0] d;
        logic       ok;
        @(negedge clock);
        if (resetn && txd_pin === 1'b0) begin
            ok = 1'b1;
            d  = 8'h00;
            repeat (BIT / 2) @(negedge clock);
            if (txd_pin !== 1'b0) ok = 1'b0;
            for (int b = 0; b < 8; b++) begin
                repeat (BIT) @(negedge clock);
                d[b] = txd_pin;
            end
`ifdef RS232_TX_PARITY_EN
            repeat (BIT) @(negedge clock);
            if (txd_pin !== ^d) ok = 1'b0;
`endif
            repeat (BIT) @(negedge clock);
            if (txd_pin !== 1'b1) ok = 1'b0;
            rxq.push_back({~ok, d});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic pop_check(input string name, input logic [7:0] d);
        logic [8:0] v;
        if (rxq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no frame want %02h", name, d);
        end else begin
            v = rxq.pop_front();
            check(name, 32'(v), {23'd0, 1'b0, d});
        end
    endtask

    // Send one byte, check the exact waveform, busy length and end state; optionally drop CTS mid-frame.
    task automatic send_check(input logic [7:0] d, input logic par, input int cts_off_at, input string tag);
        logic [10:0] fr;
        int          n;
        int          errs;
        int          bcnt;
        fr      = 11'h7FF;
        fr[0]   = 1'b0;
        fr[8:1] = d;
`ifdef RS232_TX_PARITY_EN
        fr[9]   = par;
`else
        if (par === 1'bx) fr[9] = 1'b1;
`endif
        idata  = d;
        ivalid = 1'b1;
        n      = 0;
        while (!iready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (!iready) begin
            check({tag, "_accept"}, 32'(iready), 32'd1);
            ivalid = 1'b0;
            return;
        end
        @(negedge clock);
        ivalid = 1'b0;
        idata  = 8'($urandom);
        check({tag, "_start"}, {29'd0, txd_pin, busy, iready}, 32'b010);
        errs = 0;
        bcnt = 0;
        for (int i = 0; i < FB * BIT; i++) begin
            if (i == cts_off_at) ctsn_pin = 1'b1;
            if (txd_pin !== fr[i / BIT]) errs++;
            if (busy === 1'b1) bcnt++;
            @(negedge clock);
        end
        check({tag, "_wave_errs"}, 32'(errs), 32'd0);
        check({tag, "_busy_len"}, 32'(bcnt), 32'(FB * BIT));
        check({tag, "_end"}, {29'd0, busy, iready, txd_pin}, {29'd0, 1'b0, (cts_off_at < 0), 1'b1});
        pop_check({tag, "_rx"}, d);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] b2b[$];
    int         starts[8];
    int         n;
    int         viol;
    int         cyc;
    int         idx;
    logic       fired;
    logic [7:0] r;

    initial begin
        vecs[0] = '{8'h55, 1'b0};
        vecs[1] = '{8'h07, 1'b1};
        vecs[2] = '{8'h03, 1'b0};
        vecs[3] = '{8'hFF, 1'b0};
        vecs[4] = '{8'h01, 1'b1};
        vecs[5] = '{8'hA5, 1'b0};

        resetn   = 1'b0;
        ctsn_pin = 1'b0;
        ivalid   = 1'b0;
        idata    = 8'h00;
        repeat (3) @(negedge clock);
        check("reset_state", {29'd0, txd_pin, iready, busy}, 32'b100);
        resetn = 1'b1;
        @(negedge clock);
        check("post_reset_iready", 32'(iready), 32'd0);

        // Table-driven frames, then randomized bytes.
        foreach (vecs[k]) send_check(vecs[k].data, vecs[k].par, -1, $sformatf("vec%0d", k));
        for (int k = 0; k < 4; k++) begin
            r = 8'($urandom);
            send_check(r, ^r, -1, $sformatf("rnd%0d", k));
        end

        // Back-to-back frames with ivalid held.
        b2b = '{8'h00, 8'hFF, 8'hA5};
        for (int k = 0; k < 3; k++) b2b.push_back(8'($urandom));
        idx    = 0;
        cyc    = 0;
        idata  = b2b[0];
        ivalid = 1'b1;
        while (idx < b2b.size() && cyc < 5000) begin
            fired = iready;
            @(negedge clock);
            cyc++;
            if (fired) begin
                starts[idx] = cyc;
                idx++;
                if (idx < b2b.size()) idata = b2b[idx];
                else ivalid = 1'b0;
            end
        end
        ivalid = 1'b0;
        check("b2b_count", 32'(idx), 32'(b2b.size()));
        for (int k = 1; k < idx; k++)
            check($sformatf("b2b_spacing%0d", k), 32'(starts[k] - starts[k-1]), 32'(FB * BIT + 1));
        n = 0;
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        foreach (b2b[k]) pop_check($sformatf("b2b_rx%0d", k), b2b[k]);

        // CTS deasserted: data waits with line idle.
        ctsn_pin = 1'b1;
        repeat (5) @(negedge clock);
        idata  = 8'h3C;
        ivalid = 1'b1;
        viol   = 0;
        for (int i = 0; i < 500; i++) begin
            if (iready !== 1'b0 || txd_pin !== 1'b1 || busy !== 1'b0) viol++;
            @(negedge clock);
        end
        check("cts_hold_viol", 32'(viol), 32'd0);
        ctsn_pin = 1'b0;
        n = 0;
        while (txd_pin !== 1'b0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        ivalid = 1'b0;
        total++;
        if (!(n >= 3 && n <= 4)) begin
            bad++;
            $display("FAIL cts_latency: got %0d cycles want 3..4", n);
        end
        n = 0;
        while (busy && n < 500) begin
            @(negedge clock);
            n++;
        end
        repeat (2) @(negedge clock);
        pop_check("cts_rx", 8'h3C);

        // CTS drops during bit 4: frame completes, next byte waits.
        send_check(8'h81, 1'b0, 4 * BIT + 5, "t4");
        idata  = 8'h5A;
        ivalid = 1'b1;
        viol   = 0;
        for (int i = 0; i < 200; i++) begin
            if (iready !== 1'b0 || txd_pin !== 1'b1 || busy !== 1'b0) viol++;
            @(negedge clock);
        end
        check("t4_wait_viol", 32'(viol), 32'd0);
        ctsn_pin = 1'b0;
        send_check(8'h5A, 1'b0, -1, "t4_next");

        // Reset during bit 5 abandons the frame.
        idata  = 8'h96;
        ivalid = 1'b1;
        n = 0;
        while (!iready && n < 100) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        ivalid = 1'b0;
        repeat (5 * BIT + 5) @(negedge clock);
        check("pre_rst_busy", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        check("rst_mid", {29'd0, txd_pin, iready, busy}, 32'b100);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        viol = 0;
        for (int i = 0; i < 120; i++) begin
            if (txd_pin !== 1'b1 || busy !== 1'b0) viol++;
            @(negedge clock);
        end
        check("rst_no_resume", 32'(viol), 32'd0);
        rxq.delete();
        send_check(8'h69, 1'b0, -1, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
